// File: rtl/regbus_pkg.sv
// Shared definitions for the APB to register-bus bridge.
//   rb_state_t      : bridge transfer state (IDLE, ISSUE, WAIT, DONE)
//   RB_TIMEOUT_DEF  : default rb_ready watchdog limit in cycles
//   addr_aligned()  : true when a byte address is 32-bit word aligned
package regbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } rb_state_t;

  localparam int RB_TIMEOUT_DEF = 16;

  // Only the two low address bits matter for word alignment.
  function automatic logic addr_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/regbus_wdog.sv
// Ready-timeout watchdog for the register-bus bridge.
//   clk, rst_b : clock, asynchronous active-low reset
//   clr        : zero the counter (takes priority over en)
//   en         : count one cycle of waiting
//   expire     : this counting cycle brings the count to TIMEOUT-1
module regbus_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // Expiry is flagged on the cycle whose increment lands on TIMEOUT-1,
  // so the bridge can answer the APB master on the very next cycle.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/apb_regbus_bridge.sv
// APB3 slave that turns each APB transfer into a single-cycle read or write
// strobe on the internal register bus, with word-alignment checking and a
// watchdog so a silent register-bus slave cannot stall the APB master.
//   clk, rst_b              : clock, asynchronous active-low reset
//   psel, penable, pwrite   : APB control
//   paddr, pwdata, pstrb    : APB address, write data, byte strobes
//   prdata, pready, pslverr : APB response (registered)
//   rb_addr, rb_wdata       : register-bus address and write data (held)
//   rb_wstrb                : register-bus byte strobes (0 on reads)
//   rb_we, rb_re            : one-cycle write / read strobes
//   rb_rdata, rb_ready      : register-bus read data and completion
module apb_regbus_bridge
  import regbus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = RB_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [ADDR_W-1:0]   rb_addr,
  output logic                rb_we,
  output logic                rb_re,
  output logic [DATA_W-1:0]   rb_wdata,
  output logic [DATA_W/8-1:0] rb_wstrb,
  input  logic [DATA_W-1:0]   rb_rdata,
  input  logic                rb_ready
);

  rb_state_t state;
  logic      is_write;
  logic      setup;
  logic      wdog_expire;

  assign setup = psel && !penable;

  // The counter is zeroed while the strobe is out and runs only in WAIT.
  regbus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      is_write <= 1'b0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      rb_addr  <= '0;
      rb_we    <= 1'b0;
      rb_re    <= 1'b0;
      rb_wdata <= '0;
      rb_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            is_write <= pwrite;
            if (!addr_aligned(paddr[1:0])) begin
              // Misaligned: answer with an error, never touch the bus.
              prdata  <= '0;
              pready  <= 1'b1;
              pslverr <= 1'b1;
              state   <= DONE;
            end else begin
              rb_addr  <= paddr;
              rb_wdata <= pwdata;
              rb_wstrb <= pwrite ? pstrb : '0;
              rb_we    <= pwrite;
              rb_re    <= !pwrite;
              state    <= ISSUE;
            end
          end
        end

        ISSUE, WAIT: begin
          rb_we <= 1'b0;
          rb_re <= 1'b0;
          if (!psel) begin
            // Master gave up: drop the transfer without a response.
            state <= IDLE;
          end else if (rb_ready) begin
            // rb_ready beats a simultaneous watchdog expiry.
            prdata  <= is_write ? '0 : rb_rdata;
            pready  <= 1'b1;
            pslverr <= 1'b0;
            state   <= DONE;
          end else if (wdog_expire) begin
            prdata  <= '0;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            state   <= DONE;
          end else begin
            state <= WAIT;
          end
        end

        DONE: begin
          prdata  <= '0;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// Testbench for apb_regbus_bridge: directed APB transfers against a
// transfer-level expectation timeline, plus literal timing/data pins.
module tb_apb_regbus_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int MAXC    = 256;

  logic        clk;
  logic        rst_b;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] rb_addr;
  logic        rb_we, rb_re;
  logic [31:0] rb_wdata;
  logic [3:0]  rb_wstrb;
  logic [31:0] rb_rdata;
  logic        rb_ready;

  apb_regbus_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .rb_addr  (rb_addr),
    .rb_we    (rb_we),
    .rb_re    (rb_re),
    .rb_wdata (rb_wdata),
    .rb_wstrb (rb_wstrb),
    .rb_rdata (rb_rdata),
    .rb_ready (rb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Expected output timeline, one entry per clock cycle.
  logic        e_pready  [MAXC];
  logic        e_pslverr [MAXC];
  logic        e_we      [MAXC];
  logic        e_re      [MAXC];
  logic [31:0] e_prdata  [MAXC];
  logic [31:0] e_addr    [MAXC];
  logic [31:0] e_wdata   [MAXC];
  logic [3:0]  e_wstrb   [MAXC];

  // Observations of the current transfer, used by the literal pins.
  int          last_pready_cyc;
  logic [31:0] last_prdata;
  logic        last_pslverr;
  int          we_cnt, re_cnt, we_cyc;
  logic [31:0] we_addr, we_wdata;
  logic [3:0]  we_strb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && cyc < MAXC) begin
      chk("pready",   pready,   e_pready[cyc]);
      chk("pslverr",  pslverr,  e_pslverr[cyc]);
      chk("prdata",   prdata,   e_prdata[cyc]);
      chk("rb_we",    rb_we,    e_we[cyc]);
      chk("rb_re",    rb_re,    e_re[cyc]);
      chk("rb_addr",  rb_addr,  e_addr[cyc]);
      chk("rb_wdata", rb_wdata, e_wdata[cyc]);
      chk("rb_wstrb", rb_wstrb, e_wstrb[cyc]);
    end
    if (pready === 1'b1) begin
      last_pready_cyc = cyc;
      last_prdata     = prdata;
      last_pslverr    = pslverr;
    end
    if (rb_we === 1'b1) begin
      we_cnt++;
      we_cyc   = cyc;
      we_addr  = rb_addr;
      we_wdata = rb_wdata;
      we_strb  = rb_wstrb;
    end
    if (rb_re === 1'b1) re_cnt++;
  end

  task automatic clear_obs();
    last_pready_cyc = -1;
    last_prdata     = '0;
    last_pslverr    = 1'b0;
    we_cnt = 0;
    re_cnt = 0;
    we_cyc = -1;
  endtask

  task automatic model_zero(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_pready[i] = 1'b0; e_pslverr[i] = 1'b0; e_we[i] = 1'b0; e_re[i] = 1'b0;
      e_prdata[i] = '0;   e_addr[i] = '0;      e_wdata[i] = '0; e_wstrb[i] = '0;
    end
  endtask

  // Transfer-level rules: setup at t0; k = cycles after T1 before rb_ready
  // (-1 never); abort_off = offset where psel drops (-1 none).
  task automatic model_xfer(input int t0, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st, input int k,
                            input logic [31:0] rd, input int abort_off, output int done_off);
    bit err;
    if (a[1:0] != 2'b00) begin
      done_off = 1;
      err = 1'b1;
    end else begin
      for (int i = t0 + 1; i < MAXC; i++) begin
        e_addr[i]  = a;
        e_wdata[i] = wd;
        e_wstrb[i] = wr ? st : 4'h0;
      end
      e_we[t0+1] = wr;
      e_re[t0+1] = !wr;
      if (k >= 0 && k <= TIMEOUT - 1) begin
        done_off = k + 2;
        err = 1'b0;
      end else begin
        done_off = TIMEOUT + 1;
        err = 1'b1;
      end
      if (abort_off >= 1 && abort_off < done_off) done_off = -1;
    end
    if (done_off > 0) begin
      e_pready[t0+done_off]  = 1'b1;
      e_pslverr[t0+done_off] = err;
      e_prdata[t0+done_off]  = (!wr && !err) ? rd : 32'h0;
    end
  endtask

  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int k, input logic [31:0] rd,
                         input int abort_off, input int rst_off, output int t0);
    int done_off;
    int last;
    @(posedge clk); #1;
    t0 = cyc;
    clear_obs();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    rb_ready = 1'b0; rb_rdata = rd;
    model_xfer(t0, wr, a, wd, st, k, rd, abort_off, done_off);
    last = (done_off >= 0) ? done_off : abort_off;
    if (rst_off >= 0) last = rst_off;
    for (int o = 1; o <= last; o++) begin
      @(posedge clk); #1;
      penable  = 1'b1;
      rb_ready = (k >= 0 && o == k + 1);
      if (o == abort_off) begin
        psel = 1'b0; penable = 1'b0;
      end
      if (o == rst_off) begin
        #1;
        rst_b = 1'b0; psel = 1'b0; penable = 1'b0; rb_ready = 1'b0;
        model_zero(cyc);
        #1;
        chk("rst_async_rb_addr",  rb_addr,  32'h0);
        chk("rst_async_rb_wdata", rb_wdata, 32'h0);
        @(posedge clk); #3;
        rst_b = 1'b1;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rb_ready = 1'b0;
  endtask

  int t0;

  initial begin
    rst_b = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; rb_rdata = '0; rb_ready = 1'b0;
    model_zero(0);
    clear_obs();
    #1 rst_b = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready", pready, 1'b0);
    chk("reset_prdata", prdata, 32'h0);
    #2 rst_b = 1'b1;

    // Write 0x12345678 to 0x0, rb_ready immediately.
    do_xfer(1'b1, 32'h0, 32'h1234_5678, 4'hF, 0, 32'h0, -1, -1, t0);
    chk("t1_pready_off", last_pready_cyc - t0, 2);
    chk("t1_pslverr",    last_pslverr, 1'b0);
    chk("t1_we_off",     we_cyc - t0, 1);
    chk("t1_we_cnt",     we_cnt, 1);
    chk("t1_we_addr",    we_addr, 32'h0);
    chk("t1_we_strb",    we_strb, 4'hF);
    chk("t1_we_wdata",   we_wdata, 32'h1234_5678);
    chk("t1_re_cnt",     re_cnt, 0);

    // Read 0x8, rb_ready held off three cycles.
    do_xfer(1'b0, 32'h8, 32'h0, 4'hF, 3, 32'h0020_0010, -1, -1, t0);
    chk("t2_pready_off", last_pready_cyc - t0, 5);
    chk("t2_prdata",     last_prdata, 32'h0020_0010);
    chk("t2_re_cnt",     re_cnt, 1);

    // Read 0x20, rb_ready never comes: watchdog error.
    do_xfer(1'b0, 32'h20, 32'h0, 4'h0, -1, 32'hDEAD_BEEF, -1, -1, t0);
    chk("t3_pready_off", last_pready_cyc - t0, 17);
    chk("t3_pslverr",    last_pslverr, 1'b1);
    chk("t3_prdata",     last_prdata, 32'h0);
    chk("t3_re_cnt",     re_cnt, 1);

    // Misaligned write to 0x6.
    do_xfer(1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, -1, -1, t0);
    chk("t4_pready_off", last_pready_cyc - t0, 1);
    chk("t4_pslverr",    last_pslverr, 1'b1);
    chk("t4_we_cnt",     we_cnt, 0);

    // Write 0xC abandoned in WAIT, then a late rb_ready pulse.
    do_xfer(1'b1, 32'hC, 32'h0BAD_CAFE, 4'h3, -1, 32'h0, 3, -1, t0);
    @(posedge clk); #1 rb_ready = 1'b1;
    @(posedge clk); #1 rb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_pready", last_pready_cyc, -1);
    chk("t5_we_cnt",    we_cnt, 1);
    do_xfer(1'b1, 32'h0, 32'h5555_AAAA, 4'hF, 0, 32'h0, -1, -1, t0);
    chk("t5b_pready_off", last_pready_cyc - t0, 2);
    chk("t5b_pslverr",    last_pslverr, 1'b0);

    // Reset asserted during WAIT, then a read of 0x4.
    do_xfer(1'b0, 32'h10, 32'hA5A5_A5A5, 4'h0, -1, 32'h0, -1, 4, t0);
    chk("t6_no_pready", last_pready_cyc, -1);
    do_xfer(1'b0, 32'h4, 32'h0, 4'h0, 0, 32'hCAFE_F00D, -1, -1, t0);
    chk("t6b_pready_off", last_pready_cyc - t0, 2);
    chk("t6b_prdata",     last_prdata, 32'hCAFE_F00D);
    chk("t6b_re_cnt",     re_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_regbus_bridge.md
# apb_regbus_bridge

APB3 slave that converts one APB transfer at a time into a single-pulse access on the internal register bus: ADDR, DATA_WR, WE, RE, WSTRB out; DATA_RD, READY in. It sits directly upstream of testRegBlock. The top level wires its rb_* ports to the corresponding fields of the memory_32_32 interface instance. It adds address-alignment checking and a ready-timeout watchdog, so a dead register-bus slave can never hang the APB master.

## Interface
- ADDR_W, 32, APB and register-bus address width
- DATA_W, 32, data width; must be a multiple of 8
- TIMEOUT, 16, max cycles to wait for rb_ready; must be ≥2

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte strobes
- prdata  out  DATA_W  read data, valid while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid while pready=1
- rb_addr  out  ADDR_W  register-bus address (drives ADDR)
- rb_we  out  1  write pulse (drives WE)
- rb_re  out  1  read pulse (drives RE)
- rb_wdata  out  DATA_W  write data (drives DATA_WR)
- rb_wstrb  out  DATA_W/8  byte strobes (drives WSTRB)
- rb_rdata  in  DATA_W  read data (from DATA_RD)
- rb_ready  in  1  completion (from READY)

## Operation
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE; watchdog counter resets to 0.
- IDLE, on setup phase (psel=1, penable=0):
  - Capture paddr, pwrite, pwdata and pstrb (pstrb forced to 0 on reads).
  - If paddr[1:0]≠0: go to DONE with err=1. No register-bus access is made.
  - Otherwise load rb_addr, rb_wdata and rb_wstrb, and go to ISSUE.
- ISSUE (exactly one cycle):
  - rb_we=pwrite or rb_re=!pwrite is high for this cycle only.
  - Counter is cleared.
  - rb_ready is sampled. If it is 1, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - rb_we and rb_re are 0; rb_addr, rb_wdata and rb_wstrb are held.
  - Counter increments each cycle.
  - rb_ready=1: go to DONE.
  - Counter reaches TIMEOUT-1 with rb_ready=0: go to DONE with err=1.
  - If rb_ready and timeout occur in the same cycle, rb_ready wins and err=0.
- Read capture: on a read, rb_rdata is captured into prdata in the cycle rb_ready is seen. On error, prdata=0.
- DONE:
  - pready=1 and pslverr=err for exactly one cycle, then go to IDLE.
  - prdata and pslverr return to 0 in the following cycle.
- Abort: psel=0 in ISSUE, WAIT or DONE returns to IDLE immediately.
  - No pready is issued.
  - rb_we and rb_re drop.
  - Any late rb_ready is ignored.
- Back-to-back transfers: a setup phase arriving while the bridge is in DONE is not accepted. APB guarantees a new setup only follows pready.
- Reset mid-transfer: all outputs clear asynchronously and the state returns to IDLE.

## Timing
- Setup phase at T0, rb strobe at T1 (ISSUE), pready at T2 when rb_ready is seen at T1. This is the minimum of one APB wait state.
- rb_ready first seen at T1+k: pready at T2+k.
- Timeout: pready=1 with pslverr=1 at T0+TIMEOUT+1.
- Misaligned address: pready=1 with pslverr=1 at T1; rb_we and rb_re never assert.
- rb_we and rb_re are never high for more than one cycle per transfer, and never high together.

## Structure
- Shared package regbus_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT, DONE;
  - localparam RB_TIMEOUT_DEF=16;
  - a function checking address alignment.
- One sub-module, regbus_wdog: a clear/enable/expire counter parameterised by TIMEOUT, with counter width $clog2(TIMEOUT).
- The FSM and datapath stay in apb_regbus_bridge.

## Test plan
- Write 0x12345678 to 0x0, rb_ready=1 at T1 -> rb_we pulse at T1 with rb_addr=0x0 and rb_wstrb=0xF; pready=1, pslverr=0 at T2.
- Read 0x8, rb_ready held off 3 cycles with rb_rdata=0x00200010 -> rb_re single pulse; prdata=0x00200010 and pready=1 at T0+5.
- Read 0x20 with rb_ready never asserted, TIMEOUT=16 -> pslverr=1, prdata=0, pready=1 at T0+17; exactly one rb_re pulse.
- Write to 0x6 -> pslverr=1 at T1; rb_we stays 0 throughout.
- psel dropped in WAIT, then rb_ready pulses -> no pready; next write to 0x0 completes normally.
- rst_b asserted during WAIT -> all outputs 0 asynchronously; after release, a read of 0x4 completes at T2.
